// File: rtl/sim_halt_ctrl.sv
// End-of-simulation sequencer: detects ebreak, illegal commits and commit starvation,
// drains the pipeline, then pulses finish with the halt report and keeps run counters.
module sim_halt_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned WDOG_CYCLES  = 1024,
  parameter int unsigned CNT_W        = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             commit_valid,
  input  logic [31:0]      commit_inst,
  input  logic [31:0]      commit_pc,
  input  logic             commit_illegal,
  input  logic [31:0]      a0,
  output logic             halt_req,
  output logic             finish,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [31:0]      halt_code,
  output logic [31:0]      halt_pc,
  output logic             good_trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StReport, StHalted} state_e;

  localparam logic [31:0]      Ebreak    = 32'h0010_0073;
  localparam logic [31:0]      WdogLast  = 32'(WDOG_CYCLES - 1);
  localparam logic [31:0]      WdogMax   = '1;
  localparam logic [7:0]       DrainInit = 8'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e      state_q;
  logic [31:0] last_pc_q;
  logic [31:0] wdog_q;
  logic [7:0]  drain_q;

  logic trig_illegal, trig_ebreak, trig_wdog;

  // Illegal outranks ebreak; any commit in the expiry cycle suppresses the timeout.
  assign trig_illegal = commit_valid && commit_illegal;
  assign trig_ebreak  = commit_valid && !commit_illegal && (commit_inst == Ebreak);
  assign trig_wdog    = (WDOG_CYCLES != 0) && !commit_valid && (wdog_q == WdogLast);

  assign good_trap = (halt_cause == 2'd1) && (halt_code == 32'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      last_pc_q   <= '0;
      wdog_q      <= '0;
      drain_q     <= '0;
      halt_req    <= 1'b0;
      finish      <= 1'b0;
      halted      <= 1'b0;
      halt_cause  <= 2'd0;
      halt_code   <= '0;
      halt_pc     <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (cycle_cnt != CntMax) cycle_cnt <= cycle_cnt + CntOne;
          if (commit_valid) begin
            if (instret_cnt != CntMax) instret_cnt <= instret_cnt + CntOne;
            last_pc_q <= commit_pc;
            wdog_q    <= '0;
          end else if (wdog_q != WdogMax) begin
            wdog_q <= wdog_q + 32'd1;
          end

          if (trig_illegal) begin
            halt_cause <= 2'd2;
            halt_code  <= commit_inst;
            halt_pc    <= commit_pc;
          end else if (trig_ebreak) begin
            halt_cause <= 2'd1;
            halt_code  <= a0;
            halt_pc    <= commit_pc;
          end else if (trig_wdog) begin
            halt_cause <= 2'd3;
            halt_code  <= 32'hFFFF_FFFF;
            halt_pc    <= last_pc_q;
          end

          if (trig_illegal || trig_ebreak || trig_wdog) begin
            halt_req <= 1'b1;
            drain_q  <= DrainInit;
            state_q  <= StDrain;
          end
        end

        StDrain: begin
          if (cycle_cnt != CntMax) cycle_cnt <= cycle_cnt + CntOne;
          if (drain_q == 8'd0) begin
            finish  <= 1'b1;
            state_q <= StReport;
          end else begin
            drain_q <= drain_q - 8'd1;
          end
        end

        StReport: begin
          finish  <= 1'b0;
          halted  <= 1'b1;
          state_q <= StHalted;
        end

        StHalted: begin
          // Terminal until reset; report and counters hold.
        end

        default: state_q <= StRun;
      endcase
    end
  end

endmodule
